// File: rtl/video_pattern_tx_pkg.sv
// video_pattern_tx_pkg: shared pattern encodings, bar colours and FSM state type
package video_pattern_tx_pkg;

    localparam logic [1:0] PAT_BARS  = 2'b00;
    localparam logic [1:0] PAT_RAMP  = 2'b01;
    localparam logic [1:0] PAT_CHECK = 2'b10;
    localparam logic [1:0] PAT_SOLID = 2'b11;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    localparam logic [23:0] BAR_RGB [8] = '{BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
                                            BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK};

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: combinational RGB colour for a pixel position and pattern
module video_pattern_gen
    import video_pattern_tx_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int HW       = 7,
    parameter int VW       = 5
) (
    input  logic [HW-1:0] h_i,
    input  logic [VW-1:0] v_i,
    input  logic [1:0]    pat_i,
    input  logic [23:0]   solid_i,
    output logic [23:0]   rgb_o
);

    localparam int BAR_W = H_ACTIVE / 8;

    // Checker square toggles every 8 px / 8 lines: bit 3 of h xor v.
    always_comb begin
        rgb_o = pat_i == PAT_BARS  ? bar_colour(3'(h_i / HW'(BAR_W))) :
                pat_i == PAT_RAMP  ? {3{8'(h_i)}} :
                pat_i == PAT_CHECK ? (1'((8'(h_i) ^ 8'(v_i)) >> 3) ? 24'hFFFFFF : 24'h000000) :
                                     solid_i;
    end

endmodule

// File: rtl/video_pattern_tx.sv
// video_pattern_tx: test-pattern video timing generator with half-rate pixel clock
module video_pattern_tx
    import video_pattern_tx_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_ACTIVE = 16,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2
) (
    input  logic        I_CORE_CLK,
    input  logic        I_RST,
    input  logic        I_EN,
    input  logic [1:0]  I_PATTERN_SEL,
    input  logic [23:0] I_SOLID_RGB,
    output logic [23:0] O_PIX_DATA,
    output logic        O_VSYNC,
    output logic        O_HSYNC,
    output logic        O_DE,
    output logic        O_PCLK,
    output logic [15:0] O_FRAME_CNT
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DE   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DE   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic          ph_q;
    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    pat_q, pat_d;
    logic [23:0]   solid_q, solid_d;
    logic [15:0]   frame_q, frame_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [23:0]   pix_q, pix_d;
    logic [23:0]   gen_rgb;

    // Pattern and colour are taken straight from the inputs on the frame-start slot.
    wire           frame_start = (h_q == '0) && (v_q == '0);
    wire           h_last      = h_q == H_LAST;
    wire           v_last      = v_q == V_LAST;
    wire           live        = (state_q == RUN) || I_EN;
    wire [1:0]     pat_cur     = frame_start ? I_PATTERN_SEL : pat_q;
    wire [23:0]    solid_cur   = frame_start ? I_SOLID_RGB : solid_q;

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .HW       (HW),
        .VW       (VW)
    ) u_gen (
        .h_i     (h_q),
        .v_i     (v_q),
        .pat_i   (pat_cur),
        .solid_i (solid_cur),
        .rgb_o   (gen_rgb)
    );

    // Pixel-slot update: decode current (h,v) onto outputs, then advance position and FSM.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        frame_d = frame_q;
        de_d    = de_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        pix_d   = pix_q;
        if (ph_q) begin
            de_d  = live && (h_q < H_DE) && (v_q < V_DE);
            hs_d  = live && (h_q >= HS_BEG) && (h_q < HS_END);
            vs_d  = live && (v_q >= VS_BEG) && (v_q < VS_END);
            pix_d = de_d ? gen_rgb : 24'h0;
            if (live) begin
                state_d = RUN;
                pat_d   = pat_cur;
                solid_d = solid_cur;
                h_d     = h_last ? '0 : h_q + 1'b1;
                v_d     = !h_last ? v_q : v_last ? '0 : v_q + 1'b1;
                if (h_last && v_last) begin
                    frame_d = frame_q + 16'd1;
                    state_d = I_EN ? RUN : IDLE;
                end
            end
        end
    end

    // State registers; ph toggles every core cycle and doubles as the pixel clock.
    always_ff @(posedge I_CORE_CLK or negedge I_RST) begin
        if (!I_RST) begin
            ph_q    <= 1'b0;
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            pat_q   <= PAT_BARS;
            solid_q <= 24'h0;
            frame_q <= 16'h0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            pix_q   <= 24'h0;
        end else begin
            ph_q    <= ~ph_q;
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            frame_q <= frame_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            pix_q   <= pix_d;
        end
    end

    assign O_PCLK      = ph_q;
    assign O_DE        = de_q;
    assign O_HSYNC     = hs_q;
    assign O_VSYNC     = vs_q;
    assign O_PIX_DATA  = pix_q;
    assign O_FRAME_CNT = frame_q;

endmodule

// File: tb/tb_video_pattern_tx.sv
// tb_video_pattern_tx: directed self-checking bench for video_pattern_tx
module tb_video_pattern_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  pat_sel;
    logic [23:0] solid;
    logic [23:0] pix;
    logic        vsync, hsync, de, pclk;
    logic [15:0] fcnt;

    int checks = 0;
    int errors = 0;

    bit chg_pat = 1'b0;
    int drop_v  = -1;
    int stop_i  = -1;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_pattern_tx dut (
        .I_CORE_CLK    (clk),
        .I_RST         (rst_n),
        .I_EN          (en),
        .I_PATTERN_SEL (pat_sel),
        .I_SOLID_RGB   (solid),
        .O_PIX_DATA    (pix),
        .O_VSYNC       (vsync),
        .O_HSYNC       (hsync),
        .O_DE          (de),
        .O_PCLK        (pclk),
        .O_FRAME_CNT   (fcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel slot: the ph=1 edge, then the slot edge; samples 1ns after each.
    task automatic step();
        @(posedge clk);
        #1;
        check("pclk_hi", 64'(pclk), 64'd1);
        @(posedge clk);
        #1;
        check("pclk_lo", 64'(pclk), 64'd0);
    endtask

    function automatic logic [63:0] exp_slot(input int h, input int v, input logic [1:0] p,
                                             input logic [23:0] s, input logic [15:0] fc);
        logic [7:0]  hb  = 8'(h);
        logic [7:0]  vb  = 8'(v);
        logic        e   = (h < 64) && (v < 16);
        logic        hs  = (h >= 68) && (h < 76);
        logic        vs  = (v >= 18) && (v < 20);
        logic [23:0] c;
        case (p)
            2'b00:   c = BARS[h / 8];
            2'b01:   c = {hb, hb, hb};
            2'b10:   c = (hb[3] ^ vb[3]) ? 24'hFFFFFF : 24'h000000;
            default: c = s;
        endcase
        return {21'd0, e, hs, vs, e ? c : 24'h0, fc};
    endfunction

    function automatic logic [63:0] got_slot();
        return {21'd0, de, hsync, vsync, pix, fcnt};
    endfunction

    // Walks a frame slot by slot from (0,0); p/s are the values the frame must have latched.
    task automatic run_frame(input logic [1:0] p, input logic [23:0] s, input logic [15:0] fc0);
        int de_n = 0;
        int hs_n = 0;
        int vs_n = 0;
        bit full = 1'b1;
        for (int i = 0; i < 1760; i++) begin
            int h = i % 80;
            int v = i / 80;
            step();
            check($sformatf("px h=%0d v=%0d", h, v), got_slot(),
                  exp_slot(h, v, p, s, (i == 1759) ? fc0 + 16'd1 : fc0));
            de_n += int'(de);
            hs_n += int'(hsync);
            vs_n += int'(vsync);
            if (chg_pat && h == 30 && v == 5) pat_sel = 2'b10;
            if (v == drop_v && h == 0) en = 1'b0;
            if (i == stop_i) begin
                full = 1'b0;
                break;
            end
        end
        if (full) begin
            check("de_slots", 64'(de_n), 64'd1024);
            check("hsync_slots", 64'(hs_n), 64'd176);
            check("vsync_slots", 64'(vs_n), 64'd160);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        pat_sel = 2'b00;
        solid   = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pclk", 64'(pclk), 64'd0);
        check("rst_outs", got_slot(), 64'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        run_frame(2'b00, 24'h0, 16'd0);
        chg_pat = 1'b1;
        run_frame(2'b00, 24'h0, 16'd1);
        chg_pat = 1'b0;
        run_frame(2'b10, 24'h0, 16'd2);
        drop_v = 3;
        run_frame(2'b10, 24'h0, 16'd3);
        drop_v = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("idle %0d", i), got_slot(), 64'd4);
        end
        pat_sel = 2'b11;
        solid   = 24'h123456;
        en      = 1'b1;
        stop_i  = 10 * 80 + 40;
        run_frame(2'b11, 24'h123456, 16'd4);
        stop_i  = -1;
        rst_n   = 1'b0;
        #1;
        check("async_rst_outs", got_slot(), 64'd0);
        @(posedge clk);
        #1;
        check("async_rst_pclk", 64'(pclk), 64'd0);
        rst_n = 1'b1;
        run_frame(2'b11, 24'h123456, 16'd0);
        force dut.frame_q = 16'hFFFF;
        #1;
        release dut.frame_q;
        check("forced_cnt", 64'(fcnt), 64'hFFFF);
        run_frame(2'b11, 24'h123456, 16'hFFFF);
        check("cnt_wrapped", 64'(fcnt), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
